// File: rtl/pc_fetch_if.sv
// Fetch-unit signal bundle: instruction memory req/gnt/rvalid, jump redirect, downstream valid/ready.
// FETCH_MISALIGN_CHECK_EN adds the misalign_err flag.
interface pc_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   modport master (
      output imem_req, imem_addr, out_valid, out_pc, out_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
      output misalign_err,
`endif
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_pc, out_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
      input  misalign_err,
`endif
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: single outstanding fetch, 2-entry {pc,instr} buffer, redirect flush.
// FETCH_MISALIGN_CHECK_EN: misaligned redirects are ignored and flagged on misalign_err.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst_n,
   pc_fetch_if.master bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, STALL, DROP} state_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inflight_q, inflight_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            req_q, req_d;
   entry_t          ent0_q, ent0_d, ent1_q, ent1_d;
   logic            v0_q, v0_d, v1_q, v1_d;
   logic            redir_take;
   logic [XLEN-1:0] redir_target;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   assign redir_take   = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
   assign misalign_d   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
   assign redir_target = bus.redirect_pc;
   assign bus.misalign_err = misalign_q;
`else
   assign redir_take   = bus.redirect_valid;
   assign redir_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

   // Next state: FIFO pop first, then FSM/push, then redirect overrides everything.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inflight_d = inflight_q;
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      v0_d       = v0_q;
      v1_d       = v1_q;

      if (v0_q && bus.out_ready) begin
         ent0_d = ent1_q;
         v0_d   = v1_q;
         v1_d   = 1'b0;
      end

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (bus.imem_gnt) begin
               inflight_d = pc_q;
               pc_d       = pc_q + XLEN'(4);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               if (!v0_d) begin
                  ent0_d  = '{pc: inflight_q, instr: bus.imem_rdata};
                  v0_d    = 1'b1;
                  state_d = REQ;
               end else begin
                  ent1_d  = '{pc: inflight_q, instr: bus.imem_rdata};
                  v1_d    = 1'b1;
                  state_d = STALL;
               end
            end
         end
         STALL: if (!(v0_d && v1_d)) state_d = REQ;
         DROP:  if (bus.imem_rvalid) state_d = REQ;
         default: state_d = IDLE;
      endcase

      if (redir_take) begin
         v0_d = 1'b0;
         v1_d = 1'b0;
         pc_d = redir_target;
         case (state_q)
            WAIT:    state_d = bus.imem_rvalid ? REQ : DROP;
            REQ:     state_d = bus.imem_gnt ? DROP : REQ;
            DROP:    state_d = bus.imem_rvalid ? REQ : DROP;
            default: state_d = REQ;
         endcase
      end

      req_d  = (state_d == REQ);
      addr_d = pc_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         inflight_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         ent0_q     <= '0;
         ent1_q     <= '0;
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`endif

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.out_valid = v0_q;
   assign bus.out_pc    = ent0_q.pc;
   assign bus.out_instr = ent0_q.instr;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory models, scoreboard of expected {pc,instr}, wrap-around DUT.
module tb_pc_fetch_unit;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n, rst1_n;
   int   errors = 0;
   int   checks = 0;
   int   rv_delay = 1;
   bit   mpend = 1'b0;
   int   mcnt = 0;
   logic [31:0] maddr = '0;
   bit   m1pend = 1'b0;
   logic [31:0] m1addr = '0;
   ent_t sb[$];
   ent_t q1[$];

   always #5 clk = ~clk;

   pc_fetch_if if0 ();
   pc_fetch_if if1 ();

   pc_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic ent_t mk(input logic [31:0] a);
      return '{pc: a, instr: instr_of(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Zero-wait grant; response rv_delay cycles after the grant.
   assign if0.imem_gnt = if0.imem_req;
   always @(negedge clk) begin
      if0.imem_rvalid = 1'b0;
      if (!rst_n) mpend = 1'b0;
      else begin
         if (mpend) begin
            if (mcnt <= 1) begin
               if0.imem_rvalid = 1'b1;
               if0.imem_rdata  = instr_of(maddr);
               mpend = 1'b0;
            end else mcnt--;
         end
         if (if0.imem_req && if0.imem_gnt) begin
            mpend = 1'b1;
            mcnt  = rv_delay;
            maddr = if0.imem_addr;
         end
      end
   end

   // Second instance: zero-wait memory, always ready, records its first three outputs.
   assign if1.imem_gnt       = if1.imem_req;
   assign if1.out_ready      = 1'b1;
   assign if1.redirect_valid = 1'b0;
   assign if1.redirect_pc    = 32'h0;
   always @(negedge clk) begin
      if1.imem_rvalid = m1pend;
      if1.imem_rdata  = instr_of(m1addr);
      m1pend = rst1_n && if1.imem_req;
      m1addr = if1.imem_addr;
   end
   always @(negedge clk) begin
      #1;
      if (rst1_n && if1.out_valid && q1.size() < 3) q1.push_back('{pc: if1.out_pc, instr: if1.out_instr});
   end

   // Scoreboard: every accepted output must match the head of the expected queue.
   always @(negedge clk) begin
      #1;
      if (rst_n && if0.out_valid && if0.out_ready && !if0.redirect_valid) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed_pc=%h expected=none", if0.out_pc);
         end
         if (sb.size() != 0) begin
            ent_t e;
            e = sb.pop_front();
            chk("sb_pc", if0.out_pc, e.pc);
            chk("sb_instr", if0.out_instr, e.instr);
         end
      end
   end

   task automatic do_reset(input logic rdy, input int dly);
      @(negedge clk);
      rst_n = 1'b0;
      if0.out_ready = rdy;
      if0.redirect_valid = 1'b0;
      rv_delay = dly;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
      if0.out_ready = 1'b0;
      sb.delete();
   endtask

   task automatic wait_req(input logic [31:0] a, input int budget);
      int n = 0;
      while (!(if0.imem_req && if0.imem_addr == a) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_req_in_budget", {31'b0, n < budget}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b1;
      rst1_n = 1'b1;
      if0.out_ready = 1'b1;
      if0.redirect_valid = 1'b0;
      if0.redirect_pc = 32'h0;
      if0.imem_rdata = 32'h0;
      if1.imem_rdata = 32'h0;
      #2;
      rst_n = 1'b0;
      rst1_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("rst_imem_req", {31'b0, if0.imem_req}, 32'd0);
      chk("rst_imem_addr", if0.imem_addr, 32'h100);
      chk("rst_out_pc", if0.out_pc, 32'h0);
      chk("rst_out_instr", if0.out_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_misalign", {31'b0, if0.misalign_err}, 32'd0);
`endif

      // Sequential stream, zero-wait memory, always ready
      sb.push_back(mk(32'h100));
      sb.push_back(mk(32'h104));
      sb.push_back(mk(32'h108));
      rst_n = 1'b1;
      rst1_n = 1'b1;
      #1;
      chk("req_at_release", {31'b0, if0.imem_req}, 32'd0);
      @(negedge clk);
      chk("req_1_after_release", {31'b0, if0.imem_req}, 32'd1);
      chk("first_addr", if0.imem_addr, 32'h100);
      @(negedge clk);
      chk("no_valid_yet", {31'b0, if0.out_valid}, 32'd0);
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("cadence_%0d", k), {31'b0, if0.out_valid}, 32'(k % 2));
      end
      drain(5);

      // Backpressure: buffer fills to two and fetching stops
      do_reset(1'b0, 1);
      repeat (10) @(negedge clk);
      chk("bp_out_valid", {31'b0, if0.out_valid}, 32'd1);
      chk("bp_head_pc", if0.out_pc, 32'h100);
      chk("bp_head_instr", if0.out_instr, instr_of(32'h100));
      chk("bp_req_low", {31'b0, if0.imem_req}, 32'd0);
      for (int a = 32'h100; a <= 32'h10C; a += 4) sb.push_back(mk(32'(a)));
      if0.out_ready = 1'b1;
      drain(40);

      // Redirect while waiting on a slow response for 0x104
      do_reset(1'b1, 3);
      sb.push_back(mk(32'h100));
      sb.push_back(mk(32'h2000));
      wait_req(32'h104, 20);
      @(negedge clk);
      if0.redirect_valid = 1'b1;
      if0.redirect_pc = 32'h2000;
      @(negedge clk);
      if0.redirect_valid = 1'b0;
      chk("drop_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("drop_req_low", {31'b0, if0.imem_req}, 32'd0);
      drain(40);

      // Redirect coinciding with a pop while the buffer is full
      do_reset(1'b0, 1);
      repeat (10) @(negedge clk);
      chk("full_req_low", {31'b0, if0.imem_req}, 32'd0);
      sb.push_back(mk(32'h2000));
      sb.push_back(mk(32'h2004));
      if0.out_ready = 1'b1;
      if0.redirect_valid = 1'b1;
      if0.redirect_pc = 32'h2000;
      @(negedge clk);
      if0.redirect_valid = 1'b0;
      if0.out_ready = 1'b0;
      chk("flush_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("flush_req", {31'b0, if0.imem_req}, 32'd1);
      chk("flush_addr", if0.imem_addr, 32'h2000);
      if0.out_ready = 1'b1;
      drain(40);

      // Misaligned redirect target
      do_reset(1'b1, 3);
      sb.push_back(mk(32'h100));
`ifdef FETCH_MISALIGN_CHECK_EN
      sb.push_back(mk(32'h104));
      sb.push_back(mk(32'h108));
`else
      sb.push_back(mk(32'h2000));
`endif
      wait_req(32'h104, 20);
      @(negedge clk);
      if0.redirect_valid = 1'b1;
      if0.redirect_pc = 32'h2002;
      @(negedge clk);
      if0.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("misalign_pulse", {31'b0, if0.misalign_err}, 32'd1);
      @(negedge clk);
      chk("misalign_clear", {31'b0, if0.misalign_err}, 32'd0);
`else
      chk("misalign_drop_req", {31'b0, if0.imem_req}, 32'd0);
`endif
      drain(60);

      // Reset asserted while a fetch is outstanding
      do_reset(1'b1, 3);
      sb.push_back(mk(32'h100));
      wait_req(32'h104, 20);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_req", {31'b0, if0.imem_req}, 32'd0);
      chk("midrst_addr", if0.imem_addr, 32'h100);
      chk("midrst_out_valid", {31'b0, if0.out_valid}, 32'd0);
      chk("midrst_out_pc", if0.out_pc, 32'h0);
      chk("midrst_out_instr", if0.out_instr, 32'h0);
      chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
      sb.delete();
      sb.push_back(mk(32'h100));
      sb.push_back(mk(32'h104));
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart_req", {31'b0, if0.imem_req}, 32'd1);
      chk("restart_addr", if0.imem_addr, 32'h100);
      drain(40);

      // Wrap-around instance
      chk("wrap_count", 32'(q1.size()), 32'd3);
      if (q1.size() == 3) begin
         chk("wrap_pc0", q1[0].pc, 32'hFFFF_FFFC);
         chk("wrap_instr0", q1[0].instr, instr_of(32'hFFFF_FFFC));
         chk("wrap_pc1", q1[1].pc, 32'h0000_0000);
         chk("wrap_instr1", q1[1].instr, instr_of(32'h0));
         chk("wrap_pc2", q1[2].pc, 32'h0000_0004);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
